// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin controller for a word-organised data memory
// Sub-word stores run as read-modify-write because the memory only writes full words.
module dmem_arbiter #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [1:0]    req0_size,
  input  logic [AW-1:0] req0_addr,
  input  logic [31:0]   req0_wdata,
  output logic          req0_rvalid,
  output logic          req0_err,
  output logic [31:0]   req0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [1:0]    req1_size,
  input  logic [AW-1:0] req1_addr,
  input  logic [31:0]   req1_wdata,
  output logic          req1_rvalid,
  output logic          req1_err,
  output logic [31:0]   req1_rdata,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE_WR, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_rr_ptr;
  logic          r_owner;
  logic          r_we;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_sel;
  logic          w_hs;
  logic          w_err;
  logic          w_word_st;
  logic [31:0]   w_merged;

  // On a tie the round-robin pointer picks; otherwise the sole valid port wins.
  assign w_sel     = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
  assign w_hs      = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_err     = (r_size == 2'b11) ||
                     ((r_size == 2'b01) && r_addr[0]) ||
                     ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_word_st = r_we && (r_size == 2'b10);
  assign mem_addr  = r_addr[AW-1:2];

  always_comb begin
    w_merged = r_merge;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_hs) w_next = S_ACCESS;
      S_ACCESS:   w_next = (w_err || !r_we || w_word_st) ? S_RESP : S_MERGE_WR;
      S_MERGE_WR: w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_rvalid = 1'b0;
    req1_rvalid = 1'b0;
    req0_err    = 1'b0;
    req1_err    = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        req0_ready = !rst && req0_valid && !w_sel;
        req1_ready = !rst && req1_valid && w_sel;
      end
      S_ACCESS: begin
        if (w_word_st && !w_err) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      S_MERGE_WR: begin
        mem_we    = 1'b1;
        mem_wdata = w_merged;
      end
      S_RESP: begin
        req0_rvalid = !r_owner;
        req1_rvalid = r_owner;
        req0_err    = !r_owner && r_err;
        req1_err    = r_owner && r_err;
      end
      default: ;
    endcase
  end

  // Stores and errors report zero; otherwise the last loaded word is held.
  assign req0_rdata = ((r_state == S_RESP) && !r_owner && (r_we || r_err)) ? '0 : r_rdata;
  assign req1_rdata = ((r_state == S_RESP) && r_owner && (r_we || r_err)) ? '0 : r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_owner <= w_sel;
            r_we    <= w_sel ? req1_we    : req0_we;
            r_size  <= w_sel ? req1_size  : req0_size;
            r_addr  <= w_sel ? req1_addr  : req0_addr;
            r_wdata <= w_sel ? req1_wdata : req0_wdata;
          end
        end
        S_ACCESS: begin
          r_err <= w_err;
          if (!w_err && !r_we) r_rdata <= mem_rdata;
          if (!w_err && r_we && !w_word_st) r_merge <= mem_rdata;
        end
        S_RESP: r_rr_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// Bench-owned memory model; expected values are hand-computed constants.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_rvalid, req0_err;
  logic [1:0]  req0_size;
  logic [8:0]  req0_addr;
  logic [31:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_rvalid, req1_err;
  logic [1:0]  req1_size;
  logic [8:0]  req1_addr;
  logic [31:0] req1_wdata, req1_rdata;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:127];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.AW(9)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rvalid(req0_rvalid), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rvalid(req1_rvalid), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic do_req(input int port, input logic we, input logic [1:0] size,
                        input logic [8:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int wait_c, output int we_cnt, output logic [6:0] waddr);
    logic got;
    rd = '0; er = 1'b0; lat = -1; wait_c = 0; we_cnt = 0; waddr = '0; got = 1'b0;
    if (port == 0) begin
      req0_we = we; req0_size = size; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_size = size; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
      wait_c++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (got) begin
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (mem_we) begin
          we_cnt++;
          waddr = mem_addr;
        end
        if ((port == 0) ? req0_rvalid : req1_rvalid) begin
          rd  = (port == 0) ? req0_rdata : req1_rdata;
          er  = (port == 0) ? req0_err : req1_err;
          lat = k;
          break;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic txn(input string tag, input int port, input logic we, input logic [1:0] size,
                     input logic [8:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                     input int exp_we);
    logic [31:0] rd;
    logic        er;
    int          lat, wait_c, we_cnt;
    logic [6:0]  waddr;
    do_req(port, we, size, addr, wdata, rd, er, lat, wait_c, we_cnt, waddr);
    chk({tag, ".wait"}, 32'(wait_c), 32'd0);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".we_cnt"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we != 0) chk({tag, ".waddr"}, {25'd0, waddr}, {25'd0, addr[8:2]});
  endtask

  initial begin
    int          act;
    int          both;
    int          g[$];
    for (int i = 0; i < 128; i++) mem[i] = '0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_size = 2'b10; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_size = 2'b10; req1_addr = '0; req1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("reset.rvalid", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
    chk("reset.err", {30'd0, req1_err, req0_err}, 32'd0);
    chk("reset.rdata0", req0_rdata, 32'd0);
    chk("reset.mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset.mem_addr", {25'd0, mem_addr}, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    txn("st_word", 0, 1'b1, 2'b10, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    txn("ld_word", 0, 1'b0, 2'b10, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    txn("st_base1", 0, 1'b1, 2'b10, 9'h020, 32'h11223344, 32'h0, 1'b0, 2, 1);
    txn("st_byte", 0, 1'b1, 2'b00, 9'h022, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1);
    txn("ld_byte", 0, 1'b0, 2'b10, 9'h020, 32'h0, 32'h11AA3344, 1'b0, 2, 0);

    txn("st_base2", 0, 1'b1, 2'b10, 9'h020, 32'h11223344, 32'h0, 1'b0, 2, 1);
    txn("st_half_lo", 0, 1'b1, 2'b01, 9'h020, 32'hABCD5566, 32'h0, 1'b0, 3, 1);
    txn("ld_half_lo", 0, 1'b0, 2'b10, 9'h020, 32'h0, 32'h11225566, 1'b0, 2, 0);

    txn("st_base3", 0, 1'b1, 2'b10, 9'h020, 32'h11223344, 32'h0, 1'b0, 2, 1);
    txn("st_half_hi", 0, 1'b1, 2'b01, 9'h022, 32'h00005566, 32'h0, 1'b0, 3, 1);
    txn("ld_half_hi", 0, 1'b0, 2'b10, 9'h020, 32'h0, 32'h55663344, 1'b0, 2, 0);

    txn("err_half", 0, 1'b1, 2'b01, 9'h021, 32'h0000FFFF, 32'h0, 1'b1, 2, 0);
    txn("err_word", 0, 1'b1, 2'b10, 9'h012, 32'hCAFEF00D, 32'h0, 1'b1, 2, 0);
    txn("err_rsvd", 0, 1'b0, 2'b11, 9'h010, 32'h0, 32'h0, 1'b1, 2, 0);
    txn("ld_after_err", 0, 1'b0, 2'b10, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    txn("p1_lone_ld", 1, 1'b0, 2'b10, 9'h020, 32'h0, 32'h55663344, 1'b0, 2, 0);
    txn("p1_st_byte", 1, 1'b1, 2'b00, 9'h013, 32'h00000077, 32'h0, 1'b0, 3, 1);
    txn("ld_p1_byte", 0, 1'b0, 2'b10, 9'h010, 32'h0, 32'h77ADBEEF, 1'b0, 2, 0);

    // Port 0 just completed, so the pointer now favours port 1 until reset clears it.
    req0_we = 1'b1; req0_size = 2'b00; req0_addr = 9'h011; req0_wdata = 32'h99; req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid.ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.access_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    act = 0;
    repeat (4) begin
      @(negedge clk);
      if (req0_rvalid || req1_rvalid || mem_we) act++;
    end
    chk("rst_mid.activity", 32'(act), 32'd0);
    chk("rst_mid.mem", mem[4], 32'h77ADBEEF);
    @(posedge clk); #1;

    both = 0;
    req0_we = 1'b0; req0_size = 2'b10; req0_addr = 9'h010; req0_valid = 1'b1;
    req1_we = 1'b0; req1_size = 2'b10; req1_addr = 9'h020; req1_valid = 1'b1;
    for (int c = 0; c < 40 && g.size() < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both++;
      if (req0_ready) g.push_back(0);
      else if (req1_ready) g.push_back(1);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("arb.n_grants", 32'(g.size()), 32'd4);
    chk("arb.both_ready", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb.grant%0d", i), (i < g.size()) ? 32'(g[i]) : 32'd99, 32'(i % 2));
    end
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller for the single-port word-organised data memory: 128 words, 7-bit word address, full-word synchronous write, combinational read.
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Round-robin arbitration between the two ports.
- Byte and halfword stores are done as read-modify-write sequences, because the memory only writes full words.
- Returns the raw 32-bit word on loads; sign/zero extension stays in the load path.

Parameters:
- AW, 9, byte-address width; memory word address is AW-2 bits.

Ports:
- clk  in  1  clock; memory writes on posedge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request valid, N=0,1.
- reqN_ready  out  1  request accepted this cycle (valid&ready = handshake).
- reqN_we  in  1  1=store, 0=load.
- reqN_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- reqN_addr  in  AW  byte address.
- reqN_wdata  in  32  store data, right-justified.
- reqN_rvalid  out  1  one-cycle completion pulse.
- reqN_err  out  1  valid with rvalid; misaligned or reserved size.
- reqN_rdata  out  32  loaded word, valid with rvalid.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW-2  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- FSM states: IDLE, ACCESS, MERGE_WR, RESP. Reset state is IDLE.
- Reset values: all ready/rvalid/err = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rr_ptr = 0 (port 0 favoured first).
- IDLE:
  - readyN is combinational; it is asserted only for the winner.
  - Winner: the sole valid port, or on a tie the port rr_ptr points to.
  - On handshake: latch we/size/addr/wdata and owner, then go to ACCESS.
  - A request not granted keeps valid high; its inputs must stay stable until it is granted.
- ACCESS:
  - mem_addr = latched addr[AW-1:2].
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]!=0 → err=1, no memory write, go RESP.
  - Load: capture mem_rdata into rdata, go RESP.
  - Word store: mem_we=1, mem_wdata=wdata, go RESP.
  - Byte/half store: capture mem_rdata into merge register, go MERGE_WR.
- MERGE_WR:
  - mem_we=1.
  - Byte store: mem_wdata = merge with lane addr[1:0] replaced by wdata[7:0].
  - Half store: mem_wdata = merge with bits [15:0] (addr[1]=0) or [31:16] (addr[1]=1) replaced by wdata[15:0].
  - Other lanes unchanged. Go RESP.
- RESP:
  - rvalid of owner = 1 for exactly one cycle; err as determined in ACCESS.
  - rdata holds the captured word for loads; it is 0 for stores and errors.
  - rr_ptr <= ~owner. Go IDLE.
- Latency, counted from handshake cycle T:
  - load, word store, error: rvalid at T+2.
  - byte/half store: rvalid at T+3.
  - No new grant before the cycle after RESP; at most one transaction is in flight.
- mem_we is asserted only in ACCESS (word store) or MERGE_WR, and never in the same cycle as IDLE.
- rdata holds its last value until the next load completes.
- Reset mid-operation: the FSM returns to IDLE the next edge. In-flight requests are dropped with no rvalid. A partial store that has not reached MERGE_WR leaves memory untouched.
- Loads see stores completed earlier, since writes land at the posedge ending ACCESS/MERGE_WR.

Test Plan:
- Word store/load on port 0: store 0xDEADBEEF at addr 0x010, then load 0x010 → mem_we pulse with mem_addr=0x04; load rvalid at T+2 with rdata=0xDEADBEEF, err=0.
- Byte RMW: word 0x11223344 at 0x020, byte store 0xAA at 0x022 → memory reads 0x11AA3344; rvalid at T+3; other bytes unchanged.
- Half RMW: same word, half store 0x5566 at 0x020 → 0x11225566; at 0x022 → 0x55663344.
- Arbitration: both ports valid continuously, word loads → grants alternate 0,1,0,1 starting with port 0 after reset; a lone port-1 request is granted in IDLE immediately.
- Errors: half at 0x021 and word at 0x012 → err=1 with rvalid at T+2, mem_we never asserted, memory unchanged.
- Reset in ACCESS of a byte store → no rvalid, mem_we stays 0, rr_ptr=0, and the next request is accepted normally.
